fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 66 ++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and constants for the instruction fetch slice
package fetch_pkg;
  localparam int ADDR_W = 10;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit bus: instruction memory, redirect and core delivery
interface fetch_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DEPTH  = 4
);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_q;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [CW-1:0]     q_count;

  modport slave (
    output imem_addr, inst_valid, inst_data, inst_pc, q_count,
    input  imem_q, redirect, redirect_pc, inst_ready
  );

  modport master (
    input  imem_addr, inst_valid, inst_data, inst_pc, q_count,
    output imem_q, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue: registered storage, combinational head, flush
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push_i,
  input  logic [fetch_pkg::INST_W+ADDR_W-1:0] push_data_i,
  input  logic                                pop_i,
  input  logic                                flush_i,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic [fetch_pkg::INST_W+ADDR_W-1:0] head_o
);
  import fetch_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int W  = INST_W + ADDR_W;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetcher: issue control, inflight tag, redirect
module fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic   CLOCK_50,
  input  logic   RESET,
  fetch_if.slave bus
);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]        fpc_q, fpc_d, tag_q, tag_d;
  logic                     infl_q, infl_d;
  logic                     issue, push, pop, valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic [CW-1:0]            count;
  logic [INST_W+ADDR_W-1:0] head;

  assign valid = (count != '0);

  // Redirect wins over both queue ports and always issues its target
  always_comb begin
    pop        = valid && bus.inst_ready && !bus.redirect;
    push       = infl_q && !bus.redirect;
    issue_addr = bus.redirect ? bus.redirect_pc : fpc_q;
    issue      = !RESET && (bus.redirect ||
                 (int'(count) + int'(infl_q) - int'(pop) < DEPTH));
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    infl_d     = issue;
    if (issue) begin
      fpc_d = issue_addr + ADDR_W'(1);
      tag_d = issue_addr;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fpc_q  <= '0;
      tag_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      tag_q  <= tag_d;
      infl_q <= infl_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk         (CLOCK_50),
    .rst         (RESET),
    .push_i      (push),
    .push_data_i ({bus.imem_q, tag_q}),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus.imem_addr  = RESET ? '0 : issue_addr;
  assign bus.inst_valid = valid;
  assign bus.inst_data  = valid ? head[INST_W+ADDR_W-1:ADDR_W] : NOP;
  assign bus.inst_pc    = valid ? head[ADDR_W-1:0] : '0;
  assign bus.q_count    = count;
endmodule
